data_memory_ctrl: RTL and testbench

Parametrised data memory for the MIPS core. It is byte-addressed, with byte, halfword and word access sizes, byte-lane writes, and sign- or zero-extended loads. It uses a valid/ready request and response handshake with a configurable number of wait states, and it flags misaligned or out-of-range accesses as errors. It replaces the fixed 32-bit, single-cycle, chip-select memory between the MEM stage and data storage.

---
 rtl/mem_pkg.sv | 15 +
 rtl/byte_lane_ram.sv | 30 +++
 rtl/data_memory_ctrl.sv | 147 ++++++++++++++
 tb/tb_data_memory_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory controller: access-size codes and FSM states.
package mem_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_D = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

endpackage

// File: rtl/byte_lane_ram.sv
// DEPTH x WIDTH storage with per-byte write enables and a registered read port.
// No reset so the array maps onto block RAM.
module byte_lane_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic               clk,
   input  logic [WIDTH/8-1:0] i_we,
   input  logic               i_re,
   input  logic [AW-1:0]      i_addr,
   input  logic [WIDTH-1:0]   i_wdata,
   output logic [WIDTH-1:0]   o_rdata
);

   localparam int NB = WIDTH / 8;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   always_ff @(posedge clk) begin
      for (int unsigned b = 0; b < NB; b++) begin
         if (i_we[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
      if (i_re) r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with valid/ready handshakes, configurable wait states,
// byte-lane stores, sign/zero-extended loads and alignment/range error reporting.
module data_memory_ctrl
   import mem_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 1024,
   parameter int ADDR_W  = 32,
   parameter int LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WIDTH-1:0]  req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WIDTH-1:0]  resp_rdata,
   output logic              resp_err
);

   localparam int NB     = WIDTH / 8;
   localparam int OFFW   = $clog2(NB);
   localparam int IDXW   = ADDR_W - OFFW;
   localparam int RAM_AW = $clog2(DEPTH);
   localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   state_t            r_state, w_next;
   logic [3:0]        r_cnt;
   logic [1:0]        r_size;
   logic [OFFW-1:0]   r_off;
   logic              r_uns, r_err, r_load;

   logic              w_accept, w_err, w_re;
   logic [OFFW-1:0]   w_off;
   logic [IDXW-1:0]   w_index;
   logic [NB-1:0]     w_mask, w_we;
   logic [WIDTH-1:0]  w_wdata, w_raw, w_sh, w_keep, w_ext;
   logic              w_sign;

   // Request decode: lane mask, replicated store data and error classification.
   always_comb begin
      w_off   = req_addr[OFFW-1:0];
      w_index = req_addr[ADDR_W-1:OFFW];
      w_err   = ({1'b0, w_index} >= (IDXW+1)'(DEPTH));
      w_mask  = '0;
      w_wdata = '0;
      case (req_size)
         SIZE_B: begin
            w_mask  = NB'(1) << w_off;
            w_wdata = {NB{req_wdata[7:0]}};
         end
         SIZE_H: begin
            w_err   = w_err | w_off[0];
            w_mask  = NB'(3) << w_off;
            w_wdata = {(NB/2){req_wdata[15:0]}};
         end
         SIZE_W: begin
            w_err   = w_err | (|w_off[1:0]);
            w_mask  = NB'(15) << w_off;
            w_wdata = {(NB/4){req_wdata[31:0]}};
         end
         default: begin
            w_err   = w_err | (WIDTH == 32) | (|w_off);
            w_mask  = '1;
            w_wdata = req_wdata;
         end
      endcase
   end

   assign w_accept = req_valid && (r_state == ST_IDLE);
   assign w_we     = (w_accept && req_we && !w_err) ? w_mask : '0;
   assign w_re     = w_accept && !req_we && !w_err;

   byte_lane_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (RAM_AW)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_re    (w_re),
      .i_addr  (w_index[RAM_AW-1:0]),
      .i_wdata (w_wdata),
      .o_rdata (w_raw)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_next = (LATENCY == 0) ? ST_RESP : ST_WAIT;
         ST_WAIT: if (r_cnt == 4'd0) w_next = ST_RESP;
         ST_RESP: if (resp_ready) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_size <= '0;
         r_off  <= '0;
         r_uns  <= 1'b0;
         r_err  <= 1'b0;
         r_load <= 1'b0;
      end else if (w_accept) begin
         r_cnt  <= LAT_M1;
         r_size <= req_size;
         r_off  <= w_off;
         r_uns  <= req_unsigned;
         r_err  <= w_err;
         r_load <= !req_we;
      end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // Extension works off the RAM output register and the captured fields, so the
   // result is ready even with zero wait states and holds steady throughout RESP.
   always_comb begin
      w_sh = w_raw >> {r_off, 3'b000};
      case (r_size)
         SIZE_B:  begin w_keep = WIDTH'(8'hFF);          w_sign = w_sh[7];  end
         SIZE_H:  begin w_keep = WIDTH'(16'hFFFF);       w_sign = w_sh[15]; end
         SIZE_W:  begin w_keep = WIDTH'(32'hFFFF_FFFF);  w_sign = w_sh[31]; end
         default: begin w_keep = '1;                     w_sign = 1'b0;     end
      endcase
      w_ext = (w_sh & w_keep) | ((!r_uns && w_sign) ? ~w_keep : '0);
   end

   always_comb begin
      req_ready  = (r_state == ST_IDLE);
      resp_valid = (r_state == ST_RESP);
      resp_err   = resp_valid && r_err;
      resp_rdata = (resp_valid && r_load && !r_err) ? w_ext : '0;
   end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: three instances (0, 1 and 3 wait states) driven in lockstep,
// directed vectors from a table, random accesses against a byte-array model, stall and reset cases.
module tb_data_memory_ctrl;

   localparam int DEPTH = 256;
   localparam int NI    = 3;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rd;
   } vec_t;

   int lats [NI] = '{0, 1, 3};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b1;
   logic [1:0]  req_size = 2'd0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [NI-1:0] req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata [NI];

   logic [7:0]  mem_m [4*DEPTH];
   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      data_memory_ctrl #(
         .WIDTH   (32),
         .DEPTH   (DEPTH),
         .ADDR_W  (32),
         .LATENCY ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
      ) u_dut (
         .clk          (clk),
         .rst          (rst),
         .req_valid    (req_valid),
         .req_ready    (req_ready[g]),
         .req_we       (req_we),
         .req_size     (req_size),
         .req_unsigned (req_unsigned),
         .req_addr     (req_addr),
         .req_wdata    (req_wdata),
         .resp_valid   (resp_valid[g]),
         .resp_ready   (resp_ready),
         .resp_rdata   (resp_rdata[g]),
         .resp_err     (resp_err[g])
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: byte-array memory, access of 2**size bytes, little-endian assembly.
   task automatic model(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic err, output logic [31:0] rd);
      int unsigned n = 1 << size;
      longint unsigned v = 0;
      err = (size == 2'd3) || (addr % n != 0) || (addr / 4 >= DEPTH);
      rd  = '0;
      if (!err) begin
         if (we) begin
            for (int unsigned i = 0; i < n; i++) mem_m[addr + i] = 8'((wdata >> (8 * i)) & 32'hFF);
         end else begin
            for (int unsigned i = 0; i < n; i++) v = v | (longint'(mem_m[addr + i]) << (8 * i));
            if (!uns && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
            rd = v[31:0];
         end
      end
   endtask

   task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic exp_err, input logic [31:0] exp_rd, input string tag);
      logic [NI-1:0] done = '0;
      int lat [NI];
      logic [31:0] got_rd [NI];
      logic got_err [NI];
      int cyc = 0;
      int k = 0;
      @(negedge clk);
      chk({tag, " idle"}, 32'(req_ready), 32'(3'b111));
      req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1; resp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      while (done != '1 && cyc < 20) begin
         for (int g = 0; g < NI; g++) begin
            if (!done[g] && resp_valid[g]) begin
               done[g] = 1'b1; lat[g] = cyc; got_rd[g] = resp_rdata[g]; got_err[g] = resp_err[g];
            end
         end
         if (done != '1) begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      for (int g = 0; g < NI; g++) begin
         if (!done[g]) begin
            n_checks++; n_errors++;
            $display("FAIL %s timeout[%0d]: got no response expected one within 20 cycles", tag, g);
         end else begin
            chk($sformatf("%s latency[%0d]", tag, g), 32'(lat[g]), 32'(lats[g]));
            chk($sformatf("%s rdata[%0d]", tag, g), got_rd[g], exp_rd);
            chk($sformatf("%s err[%0d]", tag, g), 32'(got_err[g]), 32'(exp_err));
         end
      end
      while (req_ready != '1 && k < 8) begin
         @(posedge clk); #1;
         k++;
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, " req_ready"}, 32'(req_ready), 32'(3'b111));
      chk({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
      chk({tag, " resp_err"}, 32'(resp_err), 32'd0);
      for (int g = 0; g < NI; g++) chk($sformatf("%s rdata[%0d]", tag, g), resp_rdata[g], 32'd0);
   endtask

   initial begin
      vec_t tbl [$];
      vec_t v;
      logic e;
      logic [31:0] r, a, d;
      logic [1:0] sz;
      logic w, u;
      logic [NI-1:0] seen;
      int k;

      // {we, size, uns, addr, wdata, err, rdata}
      v = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};        tbl.push_back(v);
      v = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF};        tbl.push_back(v);
      v = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFFFFDE};        tbl.push_back(v);
      v = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0, 32'h000000DE};        tbl.push_back(v);
      v = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hFFFFBEEF};        tbl.push_back(v);
      v = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0, 32'h0000DEAD};        tbl.push_back(v);
      v = '{1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF55, 1'b0, 32'h0};        tbl.push_back(v);
      v = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD55EF};        tbl.push_back(v);
      v = '{1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0};               tbl.push_back(v);
      v = '{1'b1, 2'd2, 1'b0, 32'h12, 32'h12345678, 1'b1, 32'h0};        tbl.push_back(v);
      v = '{1'b0, 2'd2, 1'b0, 32'(4*DEPTH), 32'h0, 1'b1, 32'h0};         tbl.push_back(v);
      v = '{1'b1, 2'd2, 1'b0, 32'(4*DEPTH), 32'hCAFEF00D, 1'b1, 32'h0};  tbl.push_back(v);
      v = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0};               tbl.push_back(v);
      v = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD55EF};        tbl.push_back(v);
      v = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h1234A5A5, 1'b0, 32'h0};        tbl.push_back(v);
      v = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'hA5A555EF};        tbl.push_back(v);
      v = '{1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hFFFFFFEF};        tbl.push_back(v);
      v = '{1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b0, 32'h00000055};        tbl.push_back(v);

      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;

      foreach (tbl[i]) begin
         model(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, e, r);
         txn(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
             tbl[i].err, tbl[i].rd, $sformatf("tbl%0d", i));
      end

      for (int i = 0; i < 16; i++) begin
         d = $urandom;
         model(1'b1, 2'd2, 1'b0, 32'(4 * i), d, e, r);
         txn(1'b1, 2'd2, 1'b0, 32'(4 * i), d, e, r, "init");
      end

      for (int i = 0; i < 60; i++) begin
         w  = 1'($urandom);
         sz = 2'($urandom_range(0, 3));
         u  = 1'($urandom);
         a  = ($urandom_range(0, 9) == 0) ? 32'(4*DEPTH) + $urandom_range(0, 255) : $urandom_range(0, 63);
         d  = $urandom;
         model(w, sz, u, a, d, e, r);
         txn(w, sz, u, a, d, e, r, $sformatf("rnd%0d", i));
      end

      // Back-pressure: response held while a competing store is presented.
      model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e, r);
      @(negedge clk);
      req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
      req_valid = 1'b1; resp_ready = 1'b0;
      @(posedge clk); #1;
      req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0BADF00D; req_valid = 1'b1;
      k = 0;
      while (resp_valid != '1 && k < 10) begin
         @(posedge clk); #1;
         k++;
      end
      chk("stall all valid", 32'(resp_valid), 32'(3'b111));
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("stall resp_valid", 32'(resp_valid), 32'(3'b111));
         chk("stall req_ready", 32'(req_ready), 32'd0);
         chk("stall resp_err", 32'(resp_err), 32'd0);
         for (int g = 0; g < NI; g++) chk($sformatf("stall rdata[%0d]", g), resp_rdata[g], r);
      end
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("release resp_valid", 32'(resp_valid), 32'd0);
      chk("release req_ready", 32'(req_ready), 32'(3'b111));
      txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e, r, "post-stall");

      // Reset while loads are waiting.
      @(negedge clk);
      req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h14;
      req_valid = 1'b1; resp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_idle_outputs("midrst");
      @(negedge clk);
      rst = 1'b0;
      seen = '0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         seen = seen | resp_valid;
      end
      chk("midrst no response", 32'(seen), 32'd0);
      model(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, e, r);
      txn(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, e, r, "post-rst");
      model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e, r);
      txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e, r, "final");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      n_errors++;
      $display("FAIL watchdog: got no completion expected finish before 500000 time units");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
